// File: rtl/wb_buf_pkg.sv
// Shared memory-port types for the cache, the write-back buffer and the memory model.
package wb_buf_pkg;

  localparam int unsigned MEM_IDX_LEN = 8;
  localparam int unsigned MEM_TAG_LEN = 2;
  localparam int unsigned MEM_BLK_LEN = 32;

  typedef logic [MEM_IDX_LEN-1:0] mem_idx_t;
  typedef logic [MEM_BLK_LEN-1:0] mem_blk_t;

  typedef enum logic [1:0] {
    MEM_CMD_NONE  = 2'd0,
    MEM_CMD_LOAD  = 2'd1,
    MEM_CMD_STORE = 2'd2
  } mem_cmd_t;

  typedef struct packed {
    logic     valid;
    mem_idx_t idx;
    mem_blk_t blk;
  } wb_entry_t;

  // Pointer width for an n-entry structure (at least one bit).
  function automatic int unsigned IDX_LEN(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_buf_if.sv
// Eviction, lookup and memory-query signals between the cache, wb_buf and memory.
interface wb_buf_if #(parameter int unsigned DEPTH = 4);
  import wb_buf_pkg::*;

  localparam int unsigned CNT_LEN = IDX_LEN(DEPTH) + 1;

  logic                   evict_valid;
  mem_idx_t               evict_idx;
  mem_blk_t               evict_blk;
  logic                   evict_ready;
  logic                   lookup_valid;
  mem_idx_t               lookup_idx;
  logic                   lookup_hit;
  mem_blk_t               lookup_blk;
  logic                   load_pending;
  mem_cmd_t               mem_qry_cmd;
  mem_idx_t               mem_qry_idx;
  mem_blk_t               mem_qry_blk;
  logic [MEM_TAG_LEN-1:0] mem_ack;
  logic [CNT_LEN-1:0]     count;

  modport master (
    output evict_valid, evict_idx, evict_blk, lookup_valid, lookup_idx,
           load_pending, mem_ack,
    input  evict_ready, lookup_hit, lookup_blk, mem_qry_cmd, mem_qry_idx,
           mem_qry_blk, count
  );

  modport slave (
    input  evict_valid, evict_idx, evict_blk, lookup_valid, lookup_idx,
           load_pending, mem_ack,
    output evict_ready, lookup_hit, lookup_blk, mem_qry_cmd, mem_qry_idx,
           mem_qry_blk, count
  );

endinterface

// File: rtl/wb_buf_match.sv
// Age-ordered CAM search: youngest valid entry whose idx matches, walking from head.
module wb_buf_match
  import wb_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IW   = IDX_LEN(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] ent_i,
  input  logic [IW-1:0]         head_i,
  input  logic                  excl_head_i,
  input  mem_idx_t              idx_i,
  output logic                  hit_o,
  output logic [IW-1:0]         pos_o,
  output mem_blk_t              blk_o
);

  logic [IW-1:0] p;

  // Later (younger) matches overwrite earlier ones.
  always_comb begin
    hit_o = 1'b0;
    pos_o = head_i;
    blk_o = '0;
    p     = head_i;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      p = head_i + IW'(k);
      if (ent_i[p].valid && (ent_i[p].idx == idx_i) && !(excl_head_i && (k == 0))) begin
        hit_o = 1'b1;
        pos_o = p;
        blk_o = ent_i[p].blk;
      end
    end
  end

endmodule

// File: rtl/wb_buf.sv
// Write-back victim buffer: FIFO of dirty blocks drained as stores, with
// coalescing on push and same-cycle forwarding to cache load-miss lookups.
module wb_buf
  import wb_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic    clock,
  input logic    reset,
  wb_buf_if.slave bus
);

  localparam int unsigned IW = IDX_LEN(DEPTH);
  localparam int unsigned CW = IW + 1;

  wb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [IW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic          full, store, push, pop;
  logic          co_hit, lk_hit;
  logic [IW-1:0] co_pos, lk_pos;
  mem_blk_t      co_blk, lk_blk;
  logic          unused_match;

  assign full  = (cnt_q == CW'(DEPTH));
  assign store = !reset && (cnt_q != '0) && (!bus.load_pending || full);
  assign push  = !reset && bus.evict_valid && !full;
  assign pop   = store && (bus.mem_ack != '0);

  // Coalesce target; the head is off-limits while its store is on the port.
  wb_buf_match #(.DEPTH(DEPTH)) u_co_match (
    .ent_i       (ent_q),
    .head_i      (head_q),
    .excl_head_i (store),
    .idx_i       (bus.evict_idx),
    .hit_o       (co_hit),
    .pos_o       (co_pos),
    .blk_o       (co_blk)
  );

  wb_buf_match #(.DEPTH(DEPTH)) u_lk_match (
    .ent_i       (ent_q),
    .head_i      (head_q),
    .excl_head_i (1'b0),
    .idx_i       (bus.lookup_idx),
    .hit_o       (lk_hit),
    .pos_o       (lk_pos),
    .blk_o       (lk_blk)
  );

  assign unused_match = ^{co_blk, lk_pos};

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push) begin
      if (co_hit) begin
        ent_d[co_pos].blk = bus.evict_blk;
      end else begin
        ent_d[tail_q] = '{valid: 1'b1, idx: bus.evict_idx, blk: bus.evict_blk};
        tail_d        = tail_q + IW'(1);
      end
    end
    if (pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + IW'(1);
    end
    cnt_d = cnt_q + CW'(push && !co_hit) - CW'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.evict_ready = reset || !full;
  assign bus.count       = cnt_q;
  assign bus.mem_qry_cmd = store ? MEM_CMD_STORE : MEM_CMD_NONE;
  assign bus.mem_qry_idx = store ? ent_q[head_q].idx : '0;
  assign bus.mem_qry_blk = store ? ent_q[head_q].blk : '0;

  // The victim arriving this cycle is newer than anything stored.
  always_comb begin
    bus.lookup_hit = 1'b0;
    bus.lookup_blk = '0;
    if (!reset && bus.lookup_valid) begin
      if (push && (bus.evict_idx == bus.lookup_idx)) begin
        bus.lookup_hit = 1'b1;
        bus.lookup_blk = bus.evict_blk;
      end else if (lk_hit) begin
        bus.lookup_hit = 1'b1;
        bus.lookup_blk = lk_blk;
      end
    end
  end

endmodule
